// File: rtl/rect_fill_if.sv
// Command and frame-buffer write bundle for the rectangle fill writer.
// The slave side is the rasteriser; the master side drives commands and wr_ready.
interface rect_fill_if #(
    parameter int COLOR_W = 9
);
    logic               start;
    logic [10:0]        cx;
    logic [10:0]        cy;
    logic [10:0]        width;
    logic [10:0]        height;
    logic [COLOR_W-1:0] color;
    logic               wr_en;
    logic [10:0]        wr_x;
    logic [10:0]        wr_y;
    logic [COLOR_W-1:0] wr_data;
    logic               wr_ready;
    logic               busy;
    logic               done;

    modport master (
        output start, cx, cy, width, height, color, wr_ready,
        input  wr_en, wr_x, wr_y, wr_data, busy, done
    );

    modport slave (
        input  start, cx, cy, width, height, color, wr_ready,
        output wr_en, wr_x, wr_y, wr_data, busy, done
    );
endinterface

// File: rtl/rect_fill_writer.sv
// Sequential rectangle rasteriser: writes a solid colour over the strict interior
// of a rectangle, clipped to the visible screen, one pixel per accepted handshake.
module rect_fill_writer #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int COLOR_W = 9
) (
    input logic        clk,
    input logic        rst,
    rect_fill_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    localparam logic [11:0] X_MAX = 12'(H_RES - 1);
    localparam logic [11:0] Y_MAX = 12'(V_RES - 1);

    state_t             state_q, state_d;
    logic [10:0]        cx_q, cy_q, w_q, h_q;
    logic [COLOR_W-1:0] color_q;
    logic [10:0]        x0_q, x1_q, y1_q;
    logic [10:0]        wr_x_q, wr_x_d;
    logic [10:0]        wr_y_q, wr_y_d;

    logic [11:0] x0_c, y0_c, x_end_c, y_end_c, x1_c, y1_c;
    logic        empty_c;
    logic        xfer, col_last, row_last;

    // 12-bit bounds never wrap: worst case 2047 + 2047 - 1 still fits.
    always_comb begin
        x0_c    = {1'b0, cx_q} + 12'd1;
        y0_c    = {1'b0, cy_q} + 12'd1;
        x_end_c = {1'b0, cx_q} + {1'b0, w_q} - 12'd1;
        y_end_c = {1'b0, cy_q} + {1'b0, h_q} - 12'd1;
        x1_c    = (x_end_c > X_MAX) ? X_MAX : x_end_c;
        y1_c    = (y_end_c > Y_MAX) ? Y_MAX : y_end_c;
        empty_c = (w_q < 11'd2) || (h_q < 11'd2) || (x0_c > x1_c) || (y0_c > y1_c);
    end

    assign xfer     = (state_q == WRITE) && bus.wr_ready;
    assign col_last = (wr_x_q == x1_q);
    assign row_last = (wr_y_q == y1_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    state_d = empty_c ? DONE : WRITE;
            WRITE:   if (xfer && col_last && row_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.wr_en   = (state_q == WRITE);
        bus.busy    = (state_q != IDLE);
        bus.done    = (state_q == DONE);
        bus.wr_x    = wr_x_q;
        bus.wr_y    = wr_y_q;
        bus.wr_data = color_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_q    <= '0;
            cy_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            cx_q    <= bus.cx;
            cy_q    <= bus.cy;
            w_q     <= bus.width;
            h_q     <= bus.height;
            color_q <= bus.color;
        end
    end

    // Bounds of a non-empty command are on screen, so 11 bits hold them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
        end else if (state_q == LOAD && !empty_c) begin
            x0_q <= x0_c[10:0];
            x1_q <= x1_c[10:0];
            y1_q <= y1_c[10:0];
        end
    end

    always_comb begin
        wr_x_d = wr_x_q;
        wr_y_d = wr_y_q;
        if (state_q == LOAD && !empty_c) begin
            wr_x_d = x0_c[10:0];
            wr_y_d = y0_c[10:0];
        end else if (xfer) begin
            if (!col_last) begin
                wr_x_d = wr_x_q + 11'd1;
            end else if (!row_last) begin
                wr_x_d = x0_q;
                wr_y_d = wr_y_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_x_q <= '0;
            wr_y_q <= '0;
        end else begin
            wr_x_q <= wr_x_d;
            wr_y_q <= wr_y_d;
        end
    end

endmodule

// File: tb/tb_rect_fill_writer.sv
// Directed and randomised bench for rect_fill_writer: write order, latency,
// stall stability, clipping, start-while-busy, async reset and a hit-test cross-check.
module tb_rect_fill_writer;

    localparam int COLOR_W = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rect_fill_if #(.COLOR_W(COLOR_W)) bus ();

    rect_fill_writer #(.H_RES(640), .V_RES(480), .COLOR_W(COLOR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int tx_x[$], tx_y[$], tx_d[$];
    int ex_x[$], ex_y[$];
    int en_cycles, done_cnt, done_cyc, first_cyc, start_cyc, stall_cnt;
    bit stall_prev = 1'b0;
    int px, py, pd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.wr_ready = 1'b1;
            1:       bus.wr_ready = (cyc % 3 == 0);
            default: bus.wr_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Transfer monitor; also checks outputs hold while a write is stalled.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                stall_cnt++;
                check("stall_en", bus.wr_en, 1);
                check("stall_x", bus.wr_x, px);
                check("stall_y", bus.wr_y, py);
                check("stall_d", bus.wr_data, pd);
            end
            if (bus.wr_en) begin
                if (en_cycles == 0) first_cyc = cyc;
                en_cycles++;
                if (bus.wr_ready) begin
                    tx_x.push_back(int'(bus.wr_x));
                    tx_y.push_back(int'(bus.wr_y));
                    tx_d.push_back(int'(bus.wr_data));
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            stall_prev = bus.wr_en && !bus.wr_ready;
            px = int'(bus.wr_x);
            py = int'(bus.wr_y);
            pd = int'(bus.wr_data);
        end
    end

    task automatic clear_mon();
        tx_x.delete(); tx_y.delete(); tx_d.delete();
        ex_x.delete(); ex_y.delete();
        en_cycles = 0; done_cnt = 0; done_cyc = -1; first_cyc = -1; stall_cnt = 0;
    endtask

    task automatic issue(input int x, input int y, input int w, input int h, input int col);
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.cx     = 11'(x);
        bus.cy     = 11'(y);
        bus.width  = 11'(w);
        bus.height = 11'(h);
        bus.color  = COLOR_W'(col);
        start_cyc  = cyc;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.cx     = 11'($urandom);
        bus.cy     = 11'($urandom);
        bus.width  = 11'($urandom);
        bus.height = 11'($urandom);
        bus.color  = COLOR_W'($urandom);
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk); #1;
            if (done_cnt > 0) got = 1'b1;
        end
        check({tag, "_done"}, got, 1);
    endtask

    task automatic build_exp(input int x, input int y, input int w, input int h);
        ex_x.delete(); ex_y.delete();
        for (int yy = y; yy <= y + h && yy < 480; yy++)
            for (int xx = x; xx <= x + w && xx < 640; xx++)
                if (x < xx && xx < x + w && y < yy && yy < y + h) begin
                    ex_x.push_back(xx);
                    ex_y.push_back(yy);
                end
    endtask

    task automatic compare_exp(input string tag, input int col);
        int errs = 0;
        check({tag, "_count"}, tx_x.size(), ex_x.size());
        for (int i = 0; i < tx_x.size() && i < ex_x.size(); i++)
            if (tx_x[i] != ex_x[i] || tx_y[i] != ex_y[i] || tx_d[i] != col) errs++;
        check({tag, "_pixels"}, errs, 0);
    endtask

    task automatic exp_basic();
        int bx[6] = '{11, 12, 13, 11, 12, 13};
        int by[6] = '{21, 21, 21, 22, 22, 22};
        ex_x.delete(); ex_y.delete();
        for (int i = 0; i < 6; i++) begin
            ex_x.push_back(bx[i]);
            ex_y.push_back(by[i]);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.cx = '0; bus.cy = '0; bus.width = '0; bus.height = '0;
        bus.color = '0; bus.wr_ready = 1'b1;
        clear_mon();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_x", bus.wr_x, 0);
        check("rst_wr_y", bus.wr_y, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b0;

        // Basic fill
        rdy_mode = 0; clear_mon();
        issue(10, 20, 4, 3, 'h1A5);
        wait_done("basic", 50);
        exp_basic();
        compare_exp("basic", 'h1A5);
        check("basic_first_lat", first_cyc - start_cyc, 2);
        check("basic_done_lat", done_cyc - start_cyc, 8);
        @(negedge clk);
        check("basic_busy_after", bus.busy, 0);

        // Empty commands
        clear_mon();
        issue(5, 5, 1, 5, 'h0F0);
        wait_done("empty_w1", 20);
        check("empty_w1_en", en_cycles, 0);
        check("empty_w1_lat", done_cyc - start_cyc, 2);
        clear_mon();
        issue(5, 5, 5, 0, 'h0F0);
        wait_done("empty_h0", 20);
        check("empty_h0_en", en_cycles, 0);
        check("empty_h0_lat", done_cyc - start_cyc, 2);

        // Backpressure
        rdy_mode = 1; clear_mon();
        issue(10, 20, 4, 3, 'h1A5);
        wait_done("bp", 100);
        exp_basic();
        compare_exp("bp", 'h1A5);
        check("bp_stalled", stall_cnt > 0, 1);

        // Clipping at the bottom-right corner
        rdy_mode = 0; clear_mon();
        issue(636, 476, 10, 10, 'h155);
        wait_done("clip", 50);
        for (int yy = 477; yy <= 479; yy++)
            for (int xx = 637; xx <= 639; xx++) begin
                ex_x.push_back(xx);
                ex_y.push_back(yy);
            end
        compare_exp("clip", 'h155);
        check("clip_done_lat", done_cyc - start_cyc, 11);
        clear_mon();
        issue(700, 10, 5, 5, 'h155);
        wait_done("offscreen", 20);
        check("offscreen_en", en_cycles, 0);

        // Start during WRITE is ignored
        clear_mon();
        issue(10, 20, 4, 3, 'h1A5);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.cx = 11'd0; bus.cy = 11'd0; bus.width = 11'd50; bus.height = 11'd50;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("busy_start", 50);
        exp_basic();
        compare_exp("busy_start", 'h1A5);
        check("busy_start_lat", done_cyc - start_cyc, 8);
        repeat (3) @(negedge clk);
        check("busy_start_noqueue", bus.busy, 0);

        // Async reset after the third transfer
        clear_mon();
        issue(10, 20, 4, 3, 'h1A5);
        begin
            bit got = 1'b0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(negedge clk); #1;
                if (tx_x.size() >= 3) got = 1'b1;
            end
            check("arst_reach3", got, 1);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_wr_en", bus.wr_en, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_wr_x", bus.wr_x, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("arst_no_done", done_cnt, 0);
        check("arst_tx", tx_x.size(), 3);
        clear_mon();
        issue(10, 20, 4, 3, 'h1A5);
        wait_done("after_rst", 50);
        exp_basic();
        compare_exp("after_rst", 'h1A5);

        // Random cross-check against the strict-interior hit test
        rdy_mode = 2;
        for (int k = 0; k < 200; k++) begin
            int x, y, w, h, col;
            x   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(620, 700)) : int'($urandom_range(0, 630));
            y   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(460, 500)) : int'($urandom_range(0, 470));
            w   = int'($urandom_range(0, 12));
            h   = int'($urandom_range(0, 12));
            col = int'($urandom_range(0, 511));
            clear_mon();
            issue(x, y, w, h, col);
            wait_done("rnd", 500);
            build_exp(x, y, w, h);
            compare_exp("rnd", col);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
